// File: rtl/img_bram_streamer.sv
// img_bram_streamer: reads PIX_COUNT 32-bit words from a read-only BRAM port
// and streams their low bytes out on a valid/ready interface. A frame starts
// on each rising edge of start that arrives while idle.
// Optional feature: define IMG_BRAM_STREAMER_FRAME_CNT_EN to add a 16-bit
// frame_cnt output counting completed frames.
module img_bram_streamer #(
   parameter int PIX_COUNT = 784,
   parameter int ADDR_STEP = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        clka,
   output logic        rsta,
   output logic        ena,
   output logic [31:0] addra,
   output logic [31:0] dina,
   output logic [3:0]  wea,
   input  logic [31:0] douta,
   output logic [7:0]  m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_last,
   output logic        busy,
   output logic        done
`ifdef IMG_BRAM_STREAMER_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam int IDX_W = $clog2(PIX_COUNT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_COUNT - 1);
   localparam logic [31:0] STEP = 32'(ADDR_STEP);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t           state_reg, state_next;
   logic             start_q_reg;
   logic             start_tick;
   logic [IDX_W-1:0] idx_reg;
   logic [31:0]      addr_reg;
   logic             pend_reg, pend_last_reg;
   logic [7:0]       fifo_data_reg [2];
   logic [1:0]       fifo_last_reg;
   logic             wr_ptr_reg, rd_ptr_reg;
   logic [1:0]       occ_reg;
   logic [2:0]       load;
   logic             pop, issue, last_issue;
   logic             done_reg;
   logic             unused_douta_hi;

   // BRAM port is read-only and shares our clock/reset
   assign clka = clk;
   assign rsta = ~rst_n;
   assign ena  = 1'b1;
   assign dina = 32'd0;
   assign wea  = 4'd0;
   assign unused_douta_hi = ^douta[31:8];

   assign start_tick = start & ~start_q_reg;
   assign pop        = m_valid & m_ready;
   // words already committed to the FIFO: stored entries plus the read whose data lands next edge
   assign load       = {1'b0, occ_reg} + {2'b00, pend_reg};
   assign issue      = (state_reg == S_RUN) && (load < (3'd2 + {2'b00, pop}));
   assign last_issue = issue && (idx_reg == LAST_IDX);

   assign addra   = addr_reg;
   assign busy    = (state_reg != S_IDLE);
   assign m_valid = (occ_reg != 2'd0);
   assign m_data  = m_valid ? fifo_data_reg[rd_ptr_reg] : 8'h00;
   assign m_last  = m_valid & fifo_last_reg[rd_ptr_reg];
   assign done    = done_reg;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   // next-state logic; start edges outside IDLE fall through unused
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start_tick) state_next = S_RUN;
         S_RUN:   if (last_issue) state_next = S_DRAIN;
         S_DRAIN: if (pop && m_last) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // start edge detector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) start_q_reg <= 1'b0;
      else        start_q_reg <= start;
   end

   // read index and byte address; address holds on the last word until the frame ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg  <= '0;
         addr_reg <= 32'd0;
      end else if (state_next == S_IDLE) begin
         idx_reg  <= '0;
         addr_reg <= 32'd0;
      end else if (issue) begin
         idx_reg <= idx_reg + IDX_W'(1);
         if (!last_issue) addr_reg <= addr_reg + STEP;
      end
   end

   // track the read whose data appears on douta during the next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg      <= 1'b0;
         pend_last_reg <= 1'b0;
      end else begin
         pend_reg      <= issue;
         pend_last_reg <= last_issue;
      end
   end

   // 2-entry output FIFO; the issue throttle guarantees a push never meets a full FIFO without a pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_data_reg[0] <= 8'h00;
         fifo_data_reg[1] <= 8'h00;
         fifo_last_reg    <= 2'b00;
         wr_ptr_reg       <= 1'b0;
         rd_ptr_reg       <= 1'b0;
         occ_reg          <= 2'd0;
      end else begin
         if (pend_reg) begin
            fifo_data_reg[wr_ptr_reg] <= douta[7:0];
            fifo_last_reg[wr_ptr_reg] <= pend_last_reg;
            wr_ptr_reg                <= ~wr_ptr_reg;
         end
         if (pop) rd_ptr_reg <= ~rd_ptr_reg;
         occ_reg <= occ_reg + {1'b0, pend_reg} - {1'b0, pop};
      end
   end

   // frame-end pulse, one cycle after the final handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) done_reg <= 1'b0;
      else        done_reg <= pop & m_last;
   end

`ifdef IMG_BRAM_STREAMER_FRAME_CNT_EN
   logic [15:0] frame_cnt_reg;

   // completed-frame counter, wraps at 16 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        frame_cnt_reg <= 16'd0;
      else if (done_reg) frame_cnt_reg <= frame_cnt_reg + 16'd1;
   end

   assign frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_img_bram_streamer.sv
// Testbench for img_bram_streamer: full 784-word frames under several ready
// patterns, restart/reset corner cases, and a cycle table for PIX_COUNT=1.
module tb_img_bram_streamer;

   localparam int PIX = 784;

   logic        clk = 1'b0;
   logic        rst_n;
   int          checks = 0;
   int          errors = 0;

   // main DUT (PIX_COUNT = 784)
   logic        start, m_ready;
   logic        clka, rsta, ena, m_valid, m_last, busy, done;
   logic [31:0] addra, dina, douta;
   logic [3:0]  wea;
   logic [7:0]  m_data;

   // single-pixel DUT (PIX_COUNT = 1)
   logic        start1, rdy1;
   logic        clka1, rsta1, ena1, valid1, last1, busy1, done1;
   logic [31:0] addra1, dina1, douta1;
   logic [3:0]  wea1;
   logic [7:0]  data1;

`ifdef IMG_BRAM_STREAMER_FRAME_CNT_EN
   logic [15:0] frame_cnt, frame_cnt1;
`endif

   always #5 clk = ~clk;

   img_bram_streamer #(.PIX_COUNT(PIX), .ADDR_STEP(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .clka(clka), .rsta(rsta), .ena(ena), .addra(addra), .dina(dina), .wea(wea),
      .douta(douta), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .busy(busy), .done(done)
`ifdef IMG_BRAM_STREAMER_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   img_bram_streamer #(.PIX_COUNT(1), .ADDR_STEP(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .clka(clka1), .rsta(rsta1), .ena(ena1), .addra(addra1), .dina(dina1), .wea(wea1),
      .douta(douta1), .m_data(data1), .m_valid(valid1), .m_ready(rdy1),
      .m_last(last1), .busy(busy1), .done(done1)
`ifdef IMG_BRAM_STREAMER_FRAME_CNT_EN
      , .frame_cnt(frame_cnt1)
`endif
   );

   // BRAM models: word i holds 0x100 + i, one-cycle read latency
   initial begin
      douta  = 32'd0;
      douta1 = 32'd0;
   end
   always @(posedge clka)  douta  <= 32'h100 + (addra >> 2);
   always @(posedge clka1) douta1 <= 32'h100 + (addra1 >> 2);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // mode 0: ready always 1; mode 1: ready 1,0,0,1 repeating; mode 2: ready 1 plus a start edge at beat 100
   task automatic run_frame(input int mode, input string name);
      int         beats, done_cnt, last_cyc, first_valid;
      logic       stalled;
      logic [7:0] pd;
      logic       pl;
      beats = 0; done_cnt = 0; last_cyc = -1; first_valid = -1;
      stalled = 1'b0; pd = 8'h00; pl = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         if (mode == 1) m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         else           m_ready = 1'b1;
         if (mode == 2) start = (beats >= 100) && (beats < 103);
         #1;
         if (cyc == 0) chk({name, "_addr0"}, addra, 32'd0);
         if (m_valid && first_valid < 0) first_valid = cyc;
         if (done) begin
            done_cnt++;
            chk({name, "_done_timing"}, cyc, last_cyc + 1);
         end
         if (stalled) begin
            chk({name, "_stall_data"}, m_data, pd);
            chk({name, "_stall_last"}, m_last, pl);
         end
         if (m_valid && m_ready) begin
            chk({name, "_data"}, m_data, beats[7:0]);
            chk({name, "_last"}, m_last, (beats == PIX - 1));
            if (beats == PIX - 1) begin
               last_cyc = cyc;
               chk({name, "_addra_last"}, addra, 32'd3132);
            end
            beats++;
         end
         stalled = m_valid && !m_ready;
         pd = m_data;
         pl = m_last;
         if (last_cyc >= 0 && cyc == last_cyc + 3) break;
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk({name, "_timeout"}, (last_cyc >= 0), 1);
      chk({name, "_first_valid"}, first_valid, 2);
      chk({name, "_beats"}, beats, PIX);
      chk({name, "_done_cnt"}, done_cnt, 1);
      chk({name, "_busy_end"}, busy, 1'b0);
      chk({name, "_addra_idle"}, addra, 32'd0);
      $display("frame %s: beats=%0d done_pulses=%0d last_cycle=%0d", name, beats, done_cnt, last_cyc);
   endtask

   typedef struct {
      logic       start;
      logic       rdy;
      logic       v;
      logic       l;
      logic [7:0] d;
      logic       b;
      logic       dn;
   } vec_t;

   vec_t tbl [17];
   int   beats_r;

   initial begin
      // PIX_COUNT=1 cycle table: {start, ready} -> {valid, last, data, busy, done} after the edge
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};  // start edge -> RUN
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};  // single read -> DRAIN
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};  // beat appears with last
      tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};  // stalled, held
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};  // handshake -> done
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};  // start still high: no restart
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};  // fresh edge: frame 2
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};  // frame 3
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

      rst_n = 1'b0; start = 1'b0; m_ready = 1'b0; start1 = 1'b0; rdy1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", m_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_addra", addra, 32'd0);
      chk("rst_data", m_data, 8'h00);
      chk("rst_rsta", rsta, 1'b1);
      chk("tie_ena", ena, 1'b1);
      chk("tie_dina", dina, 32'd0);
      chk("tie_wea", wea, 4'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("run_rsta", rsta, 1'b0);
      chk("idle_busy", busy, 1'b0);

      run_frame(0, "basic");
      run_frame(1, "stall");
      run_frame(2, "restart_ignored");

      // asynchronous reset in the middle of a frame with the stream stalled
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      beats_r = 0;
      for (int c = 0; c < 3000 && beats_r < 400; c++) begin
         m_ready = 1'b1;
         #1;
         if (m_valid) begin
            chk("pre_reset_data", m_data, beats_r[7:0]);
            beats_r++;
         end
         @(posedge clk); #1;
      end
      m_ready = 1'b0;
      #2;
      chk("pre_reset_beats", beats_r, 400);
      chk("pre_reset_valid", m_valid, 1'b1);
      chk("pre_reset_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", m_valid, 1'b0);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_addra", addra, 32'd0);
      chk("async_rst_data", m_data, 8'h00);
      chk("async_rst_last", m_last, 1'b0);
      chk("async_rst_done", done, 1'b0);
      $display("reset at beat %0d: valid=%0b busy=%0b", beats_r, m_valid, busy);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post_reset_idle_busy", busy, 1'b0);
      chk("post_reset_idle_valid", m_valid, 1'b0);
      run_frame(0, "after_reset");

      // single-pixel DUT table
      for (int i = 0; i < 17; i++) begin
         start1 = tbl[i].start;
         rdy1   = tbl[i].rdy;
         @(posedge clk); #1;
         chk($sformatf("p1_valid[%0d]", i), valid1, tbl[i].v);
         chk($sformatf("p1_busy[%0d]", i), busy1, tbl[i].b);
         chk($sformatf("p1_done[%0d]", i), done1, tbl[i].dn);
         if (tbl[i].v) begin
            chk($sformatf("p1_last[%0d]", i), last1, tbl[i].l);
            chk($sformatf("p1_data[%0d]", i), data1, tbl[i].d);
         end
         $display("p1 row %0d: start=%0b ready=%0b valid=%0b last=%0b busy=%0b done=%0b",
                  i, tbl[i].start, tbl[i].rdy, valid1, last1, busy1, done1);
      end
`ifdef IMG_BRAM_STREAMER_FRAME_CNT_EN
      chk("p1_frame_cnt", frame_cnt1, 16'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
